// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Brief    : Assembles a big-endian byte stream into 32-bit words, writes them
//            to consecutive instruction-memory addresses and releases the CPU
//            hold once the HALT word lands. Optional checksum byte after HALT
//            when INSTR_LOADER_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module instr_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RECV  = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam logic [1:0] c_CHECK = 2'd3;
`endif
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = {ADDR_WIDTH{1'b1}};

    logic [1:0]            r_state;
    logic [1:0]            r_byte_idx;
    logic [23:0]           r_asm;
    logic [ADDR_WIDTH-1:0] r_ptr;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    logic [31:0] w_word;
    logic        w_last_byte;
    logic        w_is_halt;

    // The fourth byte completes the word combinationally so it can be written
    // on the same edge it is sampled.
    assign w_word      = {r_asm, rx_data};
    assign w_last_byte = rx_valid && (r_byte_idx == 2'd3);
    assign w_is_halt   = (w_word == HALT_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_byte_idx <= 2'd0;
            r_asm      <= 24'd0;
            r_ptr      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state    <= c_RECV;
                        r_byte_idx <= 2'd0;
                        r_ptr      <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        cpu_hold   <= 1'b1;
                        word_count <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        r_csum     <= 8'd0;
`endif
                    end
                end
                c_RECV: begin
                    if (rx_valid) begin
                        r_asm      <= w_word[23:0];
                        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        r_csum     <= r_csum ^ rx_data;
`endif
                    end
                    if (w_last_byte) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= r_ptr;
                        imem_wdata <= w_word;
                        word_count <= word_count + 1'b1;
                        if (w_is_halt) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                            r_state  <= c_CHECK;
`else
                            r_state  <= c_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else if (r_ptr == c_LAST_ADDR) begin
                            // Memory full: flag it rather than wrap onto address 0.
                            r_state  <= c_DONE;
                            error    <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                c_CHECK: begin
                    if (rx_valid) begin
                        error    <= (rx_data != r_csum);
                        r_state  <= c_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                end
`endif
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_loader
// Brief    : Randomised + directed bench for instr_loader (ADDR_WIDTH 8 and 2)
//            against a byte-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic       clk = 1'b0;
    logic       rst_n, start, rx_valid;
    logic [7:0] rx_data;
    always #5 clk = ~clk;

    logic        we0, hold0, busy0, done0, err0;
    logic [7:0]  addr0;
    logic [31:0] wdata0;
    logic [8:0]  wc0;
    logic        we1, hold1, busy1, done1, err1;
    logic [1:0]  addr1;
    logic [31:0] wdata1;
    logic [2:0]  wc1;

    instr_loader #(.ADDR_WIDTH(8), .HALT_WORD(HALT)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0), .cpu_hold(hold0),
        .busy(busy0), .done(done0), .error(err0), .word_count(wc0));

    instr_loader #(.ADDR_WIDTH(2), .HALT_WORD(HALT)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1), .cpu_hold(hold1),
        .busy(busy1), .done(done1), .error(err1), .word_count(wc1));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: mode 0 idle, 1 loading, 2 finished, 3 awaiting checksum.
    int          m_depth [2] = '{256, 4};
    int          m_mode  [2];
    int          m_nbytes[2];
    int          m_ptr   [2];
    logic [31:0] m_acc   [2];
    logic [7:0]  m_xor   [2];
    logic        e_we [2], e_hold[2], e_busy[2], e_done[2], e_err[2];
    int          e_addr[2], e_wc[2];
    logic [31:0] e_wdata[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_nbytes[i] = 0; m_ptr[i] = 0; m_acc[i] = 0; m_xor[i] = 0;
            e_we[i] = 0; e_addr[i] = 0; e_wdata[i] = 0; e_hold[i] = 1;
            e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0; e_wc[i] = 0;
        end
    endtask

    task automatic m_finish(input int i);
        m_mode[i] = 2; e_done[i] = 1; e_busy[i] = 0; e_hold[i] = 0;
    endtask

    task automatic model_step(input logic s, input logic v, input logic [7:0] d);
        for (int i = 0; i < 2; i++) begin
            e_we[i] = 0;
            if (m_mode[i] == 0 || m_mode[i] == 2) begin
                if (s) begin
                    m_mode[i] = 1; m_nbytes[i] = 0; m_ptr[i] = 0; m_xor[i] = 0;
                    e_busy[i] = 1; e_done[i] = 0; e_err[i] = 0; e_hold[i] = 1; e_wc[i] = 0;
                end
            end else if (m_mode[i] == 1) begin
                if (v) begin
                    m_acc[i] = {m_acc[i][23:0], d};
                    m_xor[i] = m_xor[i] ^ d;
                    m_nbytes[i]++;
                    if (m_nbytes[i] == 4) begin
                        m_nbytes[i] = 0;
                        e_we[i] = 1; e_addr[i] = m_ptr[i]; e_wdata[i] = m_acc[i];
                        e_wc[i]++;
                        if (m_acc[i] == HALT) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                            m_mode[i] = 3;
`else
                            m_finish(i);
`endif
                        end else if (m_ptr[i] == m_depth[i] - 1) begin
                            e_err[i] = 1;
                            m_finish(i);
                        end else begin
                            m_ptr[i]++;
                        end
                    end
                end
            end else if (v) begin
                e_err[i] = (d != m_xor[i]);
                m_finish(i);
            end
        end
    endtask

    int          cyc = 0;
    int          n_wr0 = 0, n_wr1 = 0;
    logic [31:0] mem0 [256];
    int          we_cycles[$];
    always @(posedge clk) cyc++;

    // Single compare process: every negedge, both instances against the model.
    always @(negedge clk) begin
        check("we0", we0, e_we[0]);         check("we1", we1, e_we[1]);
        check("addr0", addr0, e_addr[0]);   check("addr1", addr1, e_addr[1]);
        check("wdata0", wdata0, e_wdata[0]); check("wdata1", wdata1, e_wdata[1]);
        check("hold0", hold0, e_hold[0]);   check("hold1", hold1, e_hold[1]);
        check("busy0", busy0, e_busy[0]);   check("busy1", busy1, e_busy[1]);
        check("done0", done0, e_done[0]);   check("done1", done1, e_done[1]);
        check("err0", err0, e_err[0]);      check("err1", err1, e_err[1]);
        check("wc0", wc0, e_wc[0]);         check("wc1", wc1, e_wc[1]);
        if (we0) begin mem0[addr0] = wdata0; n_wr0++; we_cycles.push_back(cyc); end
        if (we1) n_wr1++;
    end

    task automatic step(input logic s, input logic v, input logic [7:0] d);
        @(negedge clk); #1;
        start = s; rx_valid = v; rx_data = d;
        model_step(s, v, d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 8'h00);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int b = 3; b >= 0; b--) begin
            step(0, 1, w[8*b +: 8]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic send_csum(input logic [7:0] c);
`ifdef INSTR_LOADER_CHECKSUM_EN
        step(0, 1, c);
`else
        if (c == 8'h00) idle(1); else idle(1);
`endif
    endtask

    int          wr_before;
    logic [31:0] rw;

    initial begin
        rst_n = 0; start = 0; rx_valid = 0; rx_data = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_hold", hold0, 1'b1);
        check("rst_busy", busy0, 1'b0);
        check("rst_wc", wc0, 9'd0);
        rst_n = 1;

        // Bytes while idle are ignored.
        for (int k = 0; k < 4; k++) step(0, 1, 8'h20 + k[7:0]);
        idle(2);
        check("idle_no_write", n_wr0, 0);

        // Basic load with a gap between bytes.
        step(1, 0, 0);
        send_word(32'h2008_0005, 1);
        send_word(HALT, 0);
        send_csum(8'h2D);
        idle(3);
        check("t1_mem0", mem0[0], 32'h2008_0005);
        check("t1_mem1", mem0[1], 32'hFFFF_FFFF);
        check("t1_done", done0, 1'b1);
        check("t1_wc", wc0, 9'd2);
        check("t1_err", err0, 1'b0);
        check("t1_hold", hold0, 1'b0);

        // Bytes after done are ignored.
        wr_before = n_wr0;
        for (int k = 0; k < 4; k++) step(0, 1, 8'h5A);
        idle(2);
        check("done_no_write", n_wr0, wr_before);

        // Back-to-back bytes, reload from address 0.
        we_cycles.delete();
        step(1, 0, 0);
        send_word(32'h0000_0001, 0);
        send_word(HALT, 0);
        send_csum(8'h01);
        idle(3);
        check("b2b_pulses", we_cycles.size(), 2);
        if (we_cycles.size() >= 2) check("b2b_spacing", we_cycles[1] - we_cycles[0], 4);
        check("b2b_mem0", mem0[0], 32'h0000_0001);
        check("b2b_wc", wc0, 9'd2);

        // Overflow on the 4-word instance; the wide one keeps loading.
        wr_before = n_wr1;
        step(1, 0, 0);
        for (int k = 0; k < 5; k++) send_word(32'h1111_1111 * (k + 1), 0);
        idle(2);
        check("ovf_err", err1, 1'b1);
        check("ovf_done", done1, 1'b1);
        check("ovf_wc", wc1, 3'd4);
        check("ovf_writes", n_wr1 - wr_before, 4);
        send_word(HALT, 0);
        send_csum(8'h00);
        idle(2);
        check("ovf_wide_wc", wc0, 9'd6);

        // Reset in the middle of a word.
        step(1, 0, 0);
        step(0, 1, 8'h12);
        step(0, 1, 8'h34);
        #2 rst_n = 0;
        model_reset();
        #1;
        check("arst_busy", busy0, 1'b0);
        check("arst_hold", hold0, 1'b1);
        check("arst_wc", wc0, 9'd0);
        idle(2);
        @(negedge clk); #1 rst_n = 1;
        step(1, 0, 0);
        send_word(32'hAABB_CCDD, 0);
        send_word(HALT, 0);
        send_csum(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
        idle(2);
        check("arst_reload_mem0", mem0[0], 32'hAABB_CCDD);

`ifdef INSTR_LOADER_CHECKSUM_EN
        for (int pass = 0; pass < 2; pass++) begin
            step(1, 0, 0);
            send_word(32'h0102_0304, 0);
            send_word(HALT, 0);
            idle(2);
            check("cs_not_done_yet", done0, 1'b0);
            step(0, 1, (pass == 0) ? 8'h04 : 8'h05);
            idle(2);
            check("cs_done", done0, 1'b1);
            check("cs_err", err0, (pass == 0) ? 1'b0 : 1'b1);
        end
`endif

        // Randomised loads with gaps, stray starts and noise bytes.
        for (int ld = 0; ld < 40; ld++) begin
            step(1, 0, 0);
            for (int w = 0; w < int'($urandom_range(1, 6)); w++) begin
                rw = $urandom;
                if (rw == HALT) rw = 32'h0;
                send_word(rw, $urandom_range(0, 2));
                if ($urandom_range(0, 7) == 0) step(1, 0, 0);
            end
            send_word(HALT, $urandom_range(0, 1));
            step(0, 1, 8'($urandom));
            for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                step(0, $urandom_range(0, 1), 8'($urandom));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
